// File: rtl/rx_word_aligner_if.sv
// Serial receive bus for the word aligner: the line side (RX/BIT_EN) and the
// aligned-symbol side (DATA_OUT and its status flags).
//
// Handshake: BIT_EN is a pure valid qualifier. RX is consumed at every rising
// CLK edge where BIT_EN is high. There is no ready; the aligner can always take
// a bit. DATA_VALID is a one-cycle strobe that marks DATA_OUT as new. The sink
// has no way to stall it, so it must capture the word in that cycle.
interface rx_word_aligner_if;
   logic       RX;
   logic       BIT_EN;
   logic [9:0] DATA_OUT;
   logic       DATA_VALID;
   logic       IS_COMMA;
   logic       LOCK;
   logic       SYNC_ERR;
   logic       STATE_DBG;   // current FSM state (0 = HUNT, 1 = LOCKED)

   modport slave (
      input  RX, BIT_EN,
      output DATA_OUT, DATA_VALID, IS_COMMA, LOCK, SYNC_ERR, STATE_DBG
   );

   modport master (
      output RX, BIT_EN,
      input  DATA_OUT, DATA_VALID, IS_COMMA, LOCK, SYNC_ERR, STATE_DBG
   );
endinterface

// File: rtl/rx_word_aligner.sv
// 8b/10b receive word aligner. It hunts for a K28.5 comma of either polarity
// and then frames the serial stream into 10-bit symbols at that boundary.
// Alignment is dropped only after MIS_LIMIT consecutive commas arrive off the
// established boundary. Non-comma words in between do not reset that count.
module rx_word_aligner #(
   parameter logic [9:0] COMMA_P   = 10'b0011111010,
   parameter logic [9:0] COMMA_N   = 10'b1100000101,
   parameter int         MIS_LIMIT = 2
) (
   input  logic              CLK,
   input  logic              reset,
   rx_word_aligner_if.slave  bus
);

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] LP_LIMIT   = 4'(MIS_LIMIT);
   localparam logic [3:0] LP_LAST_BIT = 4'd9;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [9:0] r_win;
   logic [9:0] w_win_nxt;
   logic       w_match;
   logic       w_word_end;
   logic       w_mis_hit;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [2:0] r_mcnt;
   logic [2:0] w_mcnt_nxt;
   logic [9:0] r_dout;
   logic [9:0] w_dout_nxt;
   logic       r_dv;
   logic       w_dv_nxt;
   logic       r_ic;
   logic       w_ic_nxt;
   logic       r_se;
   logic       w_se_nxt;

   // The comma is checked on the window as it will look after this bit.
   // This lets a match act at the same edge that completes it.
   assign w_win_nxt  = {r_win[8:0], bus.RX};
   assign w_match    = (w_win_nxt == COMMA_P) || (w_win_nxt == COMMA_N);
   assign w_word_end = (r_cnt == LP_LAST_BIT);
   // This misaligned comma would be the one that reaches the limit.
   assign w_mis_hit  = (({1'b0, r_mcnt} + 4'd1) == LP_LIMIT);

   // State register; reset overrides any bit presented in the same cycle
   always_ff @(posedge CLK) begin
      if (reset) r_state <= ST_HUNT;
      else       r_state <= w_state_nxt;
   end

   // Next state: lock on any comma, unlock on the limiting misaligned comma
   always_comb begin
      w_state_nxt = r_state;
      if (bus.BIT_EN) begin
         case (r_state)
            ST_HUNT: begin
               if (w_match) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
               if (!w_word_end && w_match && w_mis_hit) w_state_nxt = ST_HUNT;
            end
            default: w_state_nxt = ST_HUNT;
         endcase
      end
   end

   // Outputs and counters: word emission, bit position and misalign tracking
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_mcnt_nxt = r_mcnt;
      w_dout_nxt = r_dout;
      w_dv_nxt   = 1'b0;
      w_ic_nxt   = 1'b0;
      w_se_nxt   = 1'b0;
      if (bus.BIT_EN) begin
         case (r_state)
            ST_HUNT: begin
               // The completing comma is the first word at the new boundary
               if (w_match) begin
                  w_dout_nxt = w_win_nxt;
                  w_dv_nxt   = 1'b1;
                  w_ic_nxt   = 1'b1;
                  w_cnt_nxt  = 4'd0;
                  w_mcnt_nxt = 3'd0;
               end
            end
            ST_LOCKED: begin
               if (w_word_end) begin
                  w_dout_nxt = w_win_nxt;
                  w_dv_nxt   = 1'b1;
                  w_ic_nxt   = w_match;
                  w_cnt_nxt  = 4'd0;
                  if (w_match) w_mcnt_nxt = 3'd0;
               end else if (w_match && w_mis_hit) begin
                  // Lost lock. Drop this comma; the next one realigns.
                  w_se_nxt   = 1'b1;
                  w_cnt_nxt  = 4'd0;
                  w_mcnt_nxt = 3'd0;
               end else begin
                  // Tolerated misaligned comma: keep framing at the old boundary
                  w_cnt_nxt = r_cnt + 4'd1;
                  if (w_match) w_mcnt_nxt = r_mcnt + 3'd1;
               end
            end
            default: begin
               w_cnt_nxt  = 4'd0;
               w_mcnt_nxt = 3'd0;
            end
         endcase
      end
   end

   // Datapath registers: shift window, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_win  <= 10'd0;
         r_cnt  <= 4'd0;
         r_mcnt <= 3'd0;
         r_dout <= 10'd0;
         r_dv   <= 1'b0;
         r_ic   <= 1'b0;
         r_se   <= 1'b0;
      end else begin
         if (bus.BIT_EN) r_win <= w_win_nxt;
         r_cnt  <= w_cnt_nxt;
         r_mcnt <= w_mcnt_nxt;
         r_dout <= w_dout_nxt;
         r_dv   <= w_dv_nxt;
         r_ic   <= w_ic_nxt;
         r_se   <= w_se_nxt;
      end
   end

   assign bus.DATA_OUT   = r_dout;
   assign bus.DATA_VALID = r_dv;
   assign bus.IS_COMMA   = r_ic;
   assign bus.SYNC_ERR   = r_se;
   assign bus.LOCK       = (r_state == ST_LOCKED);
   assign bus.STATE_DBG  = r_state;

endmodule

// File: tb/tb_rx_word_aligner.sv
// Bench for rx_word_aligner. The reference model works on the bit history.
// It counts accepted bits since the lock point and frames a word every tenth
// bit from there. Directed scenarios run first, then a long random stream
// with injected commas, bit slips, idle cycles and occasional resets.
module tb_rx_word_aligner;

   localparam logic [9:0] CP  = 10'b0011111010;
   localparam logic [9:0] CN  = 10'b1100000101;
   localparam int         LIM = 2;

   logic clk;
   logic rst;

   rx_word_aligner_if u_if ();

   rx_word_aligner #(
      .COMMA_P   (CP),
      .COMMA_N   (CN),
      .MIS_LIMIT (LIM)
   ) u_dut (
      .CLK   (clk),
      .reset (rst),
      .bus   (u_if.slave)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counters for the summary line
   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   bit         hist[$];     // last (up to) 10 accepted bits, oldest first
   int         n_acc;       // bits accepted since reset
   int         lock_base;   // n_acc value at which lock was established
   bit         m_locked;
   int         m_mis;
   logic [9:0] m_dout;
   bit         m_dv;
   bit         m_ic;
   bit         m_se;

   // Random stream of pending bits
   bit pend_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_emit(input logic [9:0] w, input bit comma);
      m_dout = w;
      m_dv   = 1'b1;
      m_ic   = comma;
   endtask

   task automatic model_step(input bit r, input bit en, input bit rx);
      logic [9:0] win;
      bit         comma;
      m_dv = 1'b0;
      m_ic = 1'b0;
      m_se = 1'b0;
      if (r) begin
         hist.delete();
         n_acc     = 0;
         lock_base = 0;
         m_locked  = 1'b0;
         m_mis     = 0;
         m_dout    = 10'd0;
      end else if (en) begin
         hist.push_back(rx);
         if (hist.size() > 10) void'(hist.pop_front());
         n_acc++;
         win = 10'd0;
         foreach (hist[i]) win = {win[8:0], hist[i]};
         comma = (win == CP) || (win == CN);
         if (!m_locked) begin
            if (comma) begin
               m_locked  = 1'b1;
               lock_base = n_acc;
               m_mis     = 0;
               model_emit(win, 1'b1);
            end
         end else if (((n_acc - lock_base) % 10) == 0) begin
            model_emit(win, comma);
            if (comma) m_mis = 0;
         end else if (comma) begin
            m_mis++;
            if (m_mis == LIM) begin
               m_locked = 1'b0;
               m_se     = 1'b1;
               m_mis    = 0;
            end
         end
      end
   endtask

   // Driver: one clock cycle of stimulus, then compare the DUT with the model
   task automatic drive_bit(input bit r, input bit en, input bit rx);
      @(negedge clk);
      rst        = r;
      u_if.BIT_EN = en;
      u_if.RX     = rx;
      model_step(r, en, rx);
      @(posedge clk);
      #1;
      chk("data_valid", 32'(u_if.DATA_VALID), 32'(m_dv));
      chk("is_comma",   32'(u_if.IS_COMMA),   32'(m_ic));
      chk("sync_err",   32'(u_if.SYNC_ERR),   32'(m_se));
      chk("lock",       32'(u_if.LOCK),       32'(m_locked));
      chk("state_dbg",  32'(u_if.STATE_DBG),  32'(m_locked));
      chk("data_out",   32'(u_if.DATA_OUT),   32'(m_dout));
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 9; i >= 0; i--) drive_bit(1'b0, 1'b1, w[i]);
   endtask

   // Scoreboard
   initial begin
      logic [9:0] wd;
      rst         = 1'b1;
      u_if.BIT_EN = 1'b0;
      u_if.RX     = 1'b0;
      m_dout      = 10'd0;

      // Reset state
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b1);
      chk("rst_lock", 32'(u_if.LOCK), 32'd0);
      chk("rst_dout", 32'(u_if.DATA_OUT), 32'd0);

      // Hunt through 0x155 filler, then lock on the negative-disparity comma
      for (int k = 0; k < 3; k++) send_word(10'h155);
      chk("hunt_no_lock", 32'(u_if.LOCK), 32'd0);
      send_word(CP);
      chk("lock_dv",   32'(u_if.DATA_VALID), 32'd1);
      chk("lock_ic",   32'(u_if.IS_COMMA),   32'd1);
      chk("lock_dout", 32'(u_if.DATA_OUT),   32'h0FA);
      chk("lock_lock", 32'(u_if.LOCK),       32'd1);

      // Continuous data words
      send_word(10'h2AA);
      chk("w1_dout", 32'(u_if.DATA_OUT), 32'h2AA);
      chk("w1_ic",   32'(u_if.IS_COMMA), 32'd0);
      send_word(10'h155);
      chk("w2_dout", 32'(u_if.DATA_OUT), 32'h155);
      chk("w2_dv",   32'(u_if.DATA_VALID), 32'd1);

      // One-bit slip followed by commas: tolerate, lose lock, relock
      drive_bit(1'b0, 1'b1, 1'b0);
      send_word(CP);
      chk("slip1_lock", 32'(u_if.LOCK), 32'd1);
      chk("slip1_se",   32'(u_if.SYNC_ERR), 32'd0);
      send_word(CP);
      chk("slip2_se",   32'(u_if.SYNC_ERR), 32'd1);
      chk("slip2_lock", 32'(u_if.LOCK), 32'd0);
      chk("slip2_dv",   32'(u_if.DATA_VALID), 32'd0);
      send_word(CP);
      chk("relock_dout", 32'(u_if.DATA_OUT), 32'h0FA);
      chk("relock_lock", 32'(u_if.LOCK), 32'd1);

      // BIT_EN toggling every cycle over two words
      for (int k = 0; k < 2; k++) begin
         wd = (k == 0) ? 10'h2AA : 10'h155;
         for (int i = 9; i >= 0; i--) begin
            drive_bit(1'b0, 1'b1, wd[i]);
            drive_bit(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end
      end
      chk("toggle_dout", 32'(u_if.DATA_OUT), 32'h155);

      // Reset mid-word while a bit is presented, then relock on the positive comma
      for (int i = 9; i >= 5; i--) drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b1, 1'b1, 1'b1);
      chk("midrst_lock", 32'(u_if.LOCK), 32'd0);
      chk("midrst_se",   32'(u_if.SYNC_ERR), 32'd0);
      chk("midrst_dout", 32'(u_if.DATA_OUT), 32'd0);
      send_word(CN);
      chk("cn_dout", 32'(u_if.DATA_OUT), 32'h305);
      chk("cn_lock", 32'(u_if.LOCK), 32'd1);

      // Random stream with commas, slips, idle cycles and rare resets
      for (int c = 0; c < 4000; c++) begin
         if (pend_q.size() == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2: wd = CP;
               3, 4:    wd = CN;
               default: wd = 10'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 7) == 0) pend_q.push_back(1'($urandom_range(0, 1)));
            for (int i = 9; i >= 0; i--) pend_q.push_back(wd[i]);
         end
         if ($urandom_range(0, 299) == 0) begin
            drive_bit(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if ($urandom_range(0, 3) != 0) begin
            drive_bit(1'b0, 1'b1, pend_q.pop_front());
         end else begin
            drive_bit(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         end
      end

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rx_word_aligner.md
RX_WORD_ALIGNER -- requirements
Module: rx_word_aligner

Interface
REQ-001 The block SHALL have parameter COMMA_P, default 10'b0011111010, the K28.5 comma pattern for negative running disparity.
REQ-002 The block SHALL have parameter COMMA_N, default 10'b1100000101, the K28.5 comma pattern for positive running disparity.
REQ-003 The block SHALL have parameter MIS_LIMIT, default 2, the number of consecutive misaligned commas that forces loss of lock (legal range 1..7).
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port RX, input, 1 bit, serial line data arriving MSB-first (bit a of the 10-bit symbol first).
REQ-007 The block SHALL have port BIT_EN, input, 1 bit; when it is high, RX carries a valid bit that is accepted at this CLK edge.
REQ-008 The block SHALL have port DATA_OUT, output, 10 bits, the aligned 10-bit symbol with the first-received bit in bit 9.
REQ-009 The block SHALL have port DATA_VALID, output, 1 bit, a one-cycle pulse that marks DATA_OUT as new.
REQ-010 The block SHALL have port IS_COMMA, output, 1 bit, which is high with DATA_VALID when DATA_OUT equals COMMA_P or COMMA_N.
REQ-011 The block SHALL have port LOCK, output, 1 bit, which is high while word alignment is established.
REQ-012 The block SHALL have port SYNC_ERR, output, 1 bit, a one-cycle pulse on loss of lock.

Function
REQ-013 The block SHALL hold a 10-bit window W; on each accepted bit, W <= {W[8:0], RX}; W SHALL hold when BIT_EN is low.
REQ-014 Comma match SHALL be evaluated on the next window value {W[8:0], RX} at the accepting edge, against both COMMA_P and COMMA_N.
REQ-015 All outputs SHALL be registered; DATA_VALID/DATA_OUT/IS_COMMA SHALL appear in the cycle after the edge that accepted the tenth bit (1-cycle latency).
REQ-016 The block SHALL have a 4-bit bit counter CNT (0..9) giving the number of bits accepted for the current word.
REQ-017 The block SHALL have a misalign counter MCNT of 3 bits.
REQ-018 The state machine SHALL have two states, HUNT (LOCK=0) and LOCKED (LOCK=1).
REQ-019 In HUNT, a match SHALL cause: emit the matched window as DATA_OUT with DATA_VALID=1 and IS_COMMA=1, CNT<=0, MCNT<=0, go to LOCKED.
REQ-020 In HUNT, no DATA_VALID SHALL be produced other than on a match.
REQ-021 In LOCKED, an accepted bit with CNT!=9 SHALL set CNT<=CNT+1.
REQ-022 In LOCKED, an accepted bit with CNT==9 SHALL emit the window, pulse DATA_VALID, set CNT<=0 (wrap), and set IS_COMMA from the match result.
REQ-023 An aligned comma (match with CNT==9) SHALL clear MCNT.
REQ-024 A misaligned comma (match with CNT!=9) SHALL increment MCNT; non-comma words SHALL leave MCNT unchanged.
REQ-025 When a misaligned comma makes MCNT reach MIS_LIMIT, the block SHALL: go to HUNT, set LOCK<=0, pulse SYNC_ERR, clear CNT and MCNT, and emit no DATA_VALID for that bit.
REQ-026 The comma that triggered loss of lock SHALL NOT be used for realignment; the next match in HUNT realigns.
REQ-027 A misaligned comma below the limit SHALL NOT change alignment, and word emission SHALL continue at the old boundary.
REQ-028 BIT_EN low SHALL freeze W, CNT, MCNT and the state; DATA_VALID, IS_COMMA and SYNC_ERR SHALL be 0 in the following cycle.
REQ-029 DATA_OUT SHALL hold its last value between DATA_VALID pulses.
REQ-030 Running disparity and code validity SHALL NOT be checked; either comma polarity is accepted at any time.

Reset
REQ-031 When reset is high at a CLK edge, the block SHALL clear W, CNT, MCNT and DATA_OUT to 0, force DATA_VALID, IS_COMMA, LOCK and SYNC_ERR to 0, and enter HUNT.
REQ-032 Reset SHALL take priority over BIT_EN; a bit presented in the same cycle as reset is discarded.
REQ-033 Reset asserted mid-word in LOCKED SHALL drop LOCK in the next cycle with no SYNC_ERR pulse.

Verification
REQ-034 Reset, then 30 bits of 0x155 pattern, then 0011111010 -> DATA_VALID=1, IS_COMMA=1 and DATA_OUT=0x0FA one cycle after the 10th comma bit, with LOCK=1.
REQ-035 Locked, then stream the words 0x2AA and 0x155 with BIT_EN every cycle -> DATA_VALID pulses every 10 cycles with DATA_OUT 0x2AA then 0x155 and IS_COMMA=0.
REQ-036 Locked, then a bit-slip of one inserted bit, then 2 commas (MIS_LIMIT=2) -> first misaligned comma: no state change; second: SYNC_ERR pulse and LOCK=0; a third comma relocks with DATA_OUT=comma.
REQ-037 Locked, then BIT_EN toggled 1/0 every cycle over 20 bits -> DATA_VALID pulses only after the 10th and 20th accepted bits, with words identical to the continuous case.
REQ-038 Locked, then reset held for 1 cycle at CNT=5 concurrent with BIT_EN=1 -> all outputs 0 and HUNT next cycle, no SYNC_ERR; 1100000101 then relocks.
